dog_extrema_detector: RTL and testbench
=======================================

// Module: dog_extrema_detector
// PURPOSE
//  Consumes the four blurred streams of one octave of the Gaussian pyramid.
//  Forms three Difference-of-Gaussian (DoG) layers and buffers two lines of each.
//  Flags keypoint candidates: pixels of the middle DoG layer that are strict 3x3x3 extrema above a contrast threshold.
//  Feeds the keypoint descriptor/orientation stage with (x, y, DoG value).
// PARAMETERS
//  IMG_WIDTH   800  pixels per line; line-buffer depth
//  IMG_HEIGHT  600  lines per frame
//  THRESH      3    contrast threshold; keypoint requires |DoG centre| > THRESH
// PORTS
//  iclk             in   1   clock
//  irst             in   1   synchronous, active-high reset
//  iG1..iG4         in   9   Gaussian pixels, sigma ascending; [8]=pixel strobe, [7:0]=unsigned pixel
//  oKeypoint_valid  out  1   one-cycle pulse: keypoint at oKeypoint_x/y
//  oKeypoint_x      out  10  column of keypoint, 0..IMG_WIDTH-1
//  oKeypoint_y      out  10  row of keypoint, 0..IMG_HEIGHT-1
//  oDoG             out  9   signed middle-layer DoG value at keypoint
//  oFrame_done      out  1   one-cycle pulse after last pixel of frame is accepted
//  oSync_err        out  1   sticky: the four strobe bits disagreed in some cycle
// BEHAVIOUR
//  - Reset (synchronous, irst=1 at posedge iclk):
//    - all outputs 0; col/row counters 0; pipeline valid bits 0; oSync_err cleared.
//    - Line-buffer/window contents are don't-care.
//  - Strobe: a pixel is accepted when iG1[8]=1.
//    - If iG1[8..4] strobe bits are not all equal, oSync_err sets next cycle and holds until reset.
//    - The pixel is still processed according to iG1[8].
//    - Cycles without a strobe: nothing shifts and the counters hold; gaps of any length are legal.
//  - Stage 1 (DoG): D0=G2-G1, D1=G3-G2, D2=G4-G3.
//    - Zero-extend to 9 bits before subtracting; 9-bit two's complement, range -255..255, no saturation needed.
//    - Registered with a valid bit.
//  - Stage 2 (window):
//    - Per layer: two IMG_WIDTH-deep line buffers plus a 3x3 register window; shift only on stage-1 valid.
//    - col counts 0..IMG_WIDTH-1 and wraps to 0, incrementing row.
//    - At col=IMG_WIDTH-1 and row=IMG_HEIGHT-1 both wrap to 0 and oFrame_done pulses one cycle later.
//  - Window centre is at (col-1, row-1) relative to the pixel just shifted in.
//    - Evaluate only if col>=2 and row>=2. Border pixels (x=0, W-1, y=0, H-1) are therefore never reported.
//    - No cross-line window is ever evaluated.
//  - Stage 3 (compare): the centre C of the D1 window is compared against the other 26 values (9 D0 + 8 D1 + 9 D2).
//    - Keypoint if C > all 26 OR C < all 26 (strict; any tie rejects), AND |C| > THRESH.
//    - Signed comparisons throughout.
//  - Latency: oKeypoint_valid rises exactly 3 cycles after the posedge that samples the strobe of the pixel completing the window.
//    - At most one keypoint per accepted pixel.
//    - oKeypoint_x/y/oDoG update only with oKeypoint_valid; they hold otherwise.
//  - Reset mid-frame:
//    - Restart at (0,0) and drop in-flight pipeline stages; no keypoint pulse in the 3 cycles after reset.
//    - Stale line data is never used, because evaluation waits for row>=2 of the new frame.
// TESTING (W=8, H=6, THRESH=3 unless noted; streams with and without strobe gaps)
//  1. All G=100, 48 strobes -> no oKeypoint_valid; one oFrame_done pulse, 1 cycle after strobe 48.
//  2. G1=G2=G4=0; G3=20 at (3,2), 0 elsewhere -> exactly one keypoint, x=3, y=2, oDoG=+20.
//     oKeypoint_valid rises 3 cycles after strobe of pixel (4,3).
//  3. Test 2 with G3=3 -> |C|=3 not > THRESH -> no keypoint. With G3=4 -> keypoint, oDoG=4.
//  4. Test 2 spot at (0,2), at (7,2), and at (3,5) -> no keypoint; col/row wrap correct across 2 frames.
//  5. Test 2 with G3=20 also at (4,2) (tie) -> no keypoint. Negative spot G2=20 at (3,2) -> keypoint, oDoG=-20.
//  6. irst pulsed after 20 strobes of test-2 frame, then full frame -> exactly one keypoint (3,2).
//     With iG3[8]=0 while iG1[8]=1 for one cycle -> oSync_err=1 until irst.

Source files
------------

// File: rtl/dog_extrema_detector.sv
`default_nettype none
// ============================================================================
// Module   : dog_extrema_detector
// Brief    : Builds three DoG layers from four Gaussian streams, windows them
//            3x3x3 and flags strict extrema of the middle layer as keypoints.
// Revision : 1.0 - initial release
// ============================================================================
module dog_extrema_detector #(
    parameter int IMG_WIDTH  = 800,
    parameter int IMG_HEIGHT = 600,
    parameter int THRESH     = 3
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic [8:0]        iG1,
    input  logic [8:0]        iG2,
    input  logic [8:0]        iG3,
    input  logic [8:0]        iG4,
    output logic              oKeypoint_valid,
    output logic [9:0]        oKeypoint_x,
    output logic [9:0]        oKeypoint_y,
    output logic signed [8:0] oDoG,
    output logic              oFrame_done,
    output logic              oSync_err
);

    localparam int                c_addrW  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [9:0]        c_colMax = 10'(IMG_WIDTH - 1);
    localparam logic [9:0]        c_rowMax = 10'(IMG_HEIGHT - 1);
    localparam logic signed [8:0] c_thresh = 9'(THRESH);

    logic              w_strobe;
    logic              w_syncMis;
    logic              r_s1Valid;
    logic signed [8:0] r_s1Dog [3];
    logic              r_syncErr;

    assign w_strobe  = iG1[8];
    assign w_syncMis = !((iG1[8] == iG2[8]) && (iG1[8] == iG3[8]) && (iG1[8] == iG4[8]));

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_s1Valid <= 1'b0;
            r_syncErr <= 1'b0;
        end else begin
            r_s1Valid <= w_strobe;
            if (w_syncMis) r_syncErr <= 1'b1;
        end
    end

    // Zero-extended 9-bit subtraction cannot overflow for 8-bit pixels
    always_ff @(posedge iclk) begin
        if (w_strobe) begin
            r_s1Dog[0] <= {1'b0, iG2[7:0]} - {1'b0, iG1[7:0]};
            r_s1Dog[1] <= {1'b0, iG3[7:0]} - {1'b0, iG2[7:0]};
            r_s1Dog[2] <= {1'b0, iG4[7:0]} - {1'b0, iG3[7:0]};
        end
    end

    logic [9:0]         r_col;
    logic [9:0]         r_row;
    logic               w_colLast;
    logic               w_rowLast;
    logic               r_s2Valid;
    logic [9:0]         r_s2X;
    logic [9:0]         r_s2Y;
    logic               r_frameDone;
    logic [c_addrW-1:0] w_addr;

    assign w_colLast = (r_col == c_colMax);
    assign w_rowLast = (r_row == c_rowMax);
    assign w_addr    = r_col[c_addrW-1:0];

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_col       <= 10'd0;
            r_row       <= 10'd0;
            r_s2Valid   <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= r_s1Valid && w_colLast && w_rowLast;
            // Centre sits one column and one row behind the incoming pixel
            r_s2Valid   <= r_s1Valid && (r_col >= 10'd2) && (r_row >= 10'd2);
            if (r_s1Valid) begin
                if (w_colLast) begin
                    r_col <= 10'd0;
                    r_row <= w_rowLast ? 10'd0 : r_row + 10'd1;
                end else begin
                    r_col <= r_col + 10'd1;
                end
            end
        end
    end

    logic signed [8:0] r_lineA [3][IMG_WIDTH];
    logic signed [8:0] r_lineB [3][IMG_WIDTH];
    logic signed [8:0] r_win   [3][3][3];

    // Window indices are [layer][row][col]; row 0 is the oldest line, col 2 the newest pixel
    always_ff @(posedge iclk) begin
        if (r_s1Valid) begin
            r_s2X <= r_col - 10'd1;
            r_s2Y <= r_row - 10'd1;
            for (int l = 0; l < 3; l++) begin
                r_lineB[l][w_addr] <= r_lineA[l][w_addr];
                r_lineA[l][w_addr] <= r_s1Dog[l];
                for (int r = 0; r < 3; r++) begin
                    r_win[l][r][0] <= r_win[l][r][1];
                    r_win[l][r][1] <= r_win[l][r][2];
                end
                r_win[l][0][2] <= r_lineB[l][w_addr];
                r_win[l][1][2] <= r_lineA[l][w_addr];
                r_win[l][2][2] <= r_s1Dog[l];
            end
        end
    end

    logic signed [8:0] w_centre;
    logic              w_allGt;
    logic              w_allLt;
    logic              w_contrast;

    always_comb begin
        w_centre = r_win[1][1][1];
        w_allGt  = 1'b1;
        w_allLt  = 1'b1;
        for (int l = 0; l < 3; l++) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    if (!(l == 1 && r == 1 && c == 1)) begin
                        if (w_centre <= r_win[l][r][c]) w_allGt = 1'b0;
                        if (w_centre >= r_win[l][r][c]) w_allLt = 1'b0;
                    end
                end
            end
        end
    end

    assign w_contrast = (w_centre > c_thresh) || (w_centre < -c_thresh);

    logic              r_s3Hit;
    logic [9:0]        r_s3X;
    logic [9:0]        r_s3Y;
    logic signed [8:0] r_s3Dog;
    logic              r_kpValid;
    logic [9:0]        r_kpX;
    logic [9:0]        r_kpY;
    logic signed [8:0] r_kpDog;

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_s3Hit   <= 1'b0;
            r_kpValid <= 1'b0;
            r_kpX     <= 10'd0;
            r_kpY     <= 10'd0;
            r_kpDog   <= 9'sd0;
        end else begin
            r_s3Hit   <= r_s2Valid && (w_allGt || w_allLt) && w_contrast;
            r_kpValid <= r_s3Hit;
            if (r_s3Hit) begin
                r_kpX   <= r_s3X;
                r_kpY   <= r_s3Y;
                r_kpDog <= r_s3Dog;
            end
        end
    end

    always_ff @(posedge iclk) begin
        r_s3X   <= r_s2X;
        r_s3Y   <= r_s2Y;
        r_s3Dog <= w_centre;
    end

    assign oKeypoint_valid = r_kpValid;
    assign oKeypoint_x     = r_kpX;
    assign oKeypoint_y     = r_kpY;
    assign oDoG            = r_kpDog;
    assign oFrame_done     = r_frameDone;
    assign oSync_err       = r_syncErr;

endmodule
`default_nettype wire

// File: tb/tb_dog_extrema_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_dog_extrema_detector
// Brief    : Randomised and directed stimulus against a frame-array reference
//            model of the DoG extrema detector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dog_extrema_detector;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int TH = 3;

    logic              iclk = 1'b0;
    logic              irst;
    logic [8:0]        iG1, iG2, iG3, iG4;
    logic              oKeypoint_valid;
    logic [9:0]        oKeypoint_x;
    logic [9:0]        oKeypoint_y;
    logic signed [8:0] oDoG;
    logic              oFrame_done;
    logic              oSync_err;

    always #5 iclk = ~iclk;

    dog_extrema_detector #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .THRESH     (TH)
    ) u_dut (
        .iclk            (iclk),
        .irst            (irst),
        .iG1             (iG1),
        .iG2             (iG2),
        .iG3             (iG3),
        .iG4             (iG4),
        .oKeypoint_valid (oKeypoint_valid),
        .oKeypoint_x     (oKeypoint_x),
        .oKeypoint_y     (oKeypoint_y),
        .oDoG            (oDoG),
        .oFrame_done     (oFrame_done),
        .oSync_err       (oSync_err)
    );

    int nCompared   = 0;
    int nMismatched = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // Reference model: whole-frame images, raster position and a short
    // ring of expected outputs indexed by cycle.
    int img [4][H][W];
    int dog [3][H][W];
    int mCol, mRow;
    bit mSync;
    int cyc = 0;
    bit ringKp [8];
    bit ringFd [8];
    int ringX  [8];
    int ringY  [8];
    int ringD  [8];
    int heldX, heldY, heldD;

    function automatic bit isKeypoint(input int cx, input int cy);
        int  c  = dog[1][cy][cx];
        bit  gt = 1'b1;
        bit  lt = 1'b1;
        for (int l = 0; l < 3; l++)
            for (int dy = -1; dy <= 1; dy++)
                for (int dx = -1; dx <= 1; dx++)
                    if (!(l == 1 && dy == 0 && dx == 0)) begin
                        if (c <= dog[l][cy+dy][cx+dx]) gt = 1'b0;
                        if (c >= dog[l][cy+dy][cx+dx]) lt = 1'b0;
                    end
        return (gt || lt) && (c > TH || c < -TH);
    endfunction

    task automatic accept(input int p1, input int p2, input int p3, input int p4);
        int s;
        dog[0][mRow][mCol] = p2 - p1;
        dog[1][mRow][mCol] = p3 - p2;
        dog[2][mRow][mCol] = p4 - p3;
        if (mCol >= 2 && mRow >= 2 && isKeypoint(mCol - 1, mRow - 1)) begin
            s         = (cyc + 3) % 8;
            ringKp[s] = 1'b1;
            ringX[s]  = mCol - 1;
            ringY[s]  = mRow - 1;
            ringD[s]  = dog[1][mRow-1][mCol-1];
        end
        if (mCol == W - 1 && mRow == H - 1) begin
            ringFd[(cyc + 1) % 8] = 1'b1;
            mCol = 0;
            mRow = 0;
        end else if (mCol == W - 1) begin
            mCol = 0;
            mRow++;
        end else begin
            mCol++;
        end
    endtask

    task automatic tick(input bit rst, input bit [3:0] stb,
                        input int p1, input int p2, input int p3, input int p4);
        int s;
        irst = rst;
        iG1  = {stb[0], 8'(p1)};
        iG2  = {stb[1], 8'(p2)};
        iG3  = {stb[2], 8'(p3)};
        iG4  = {stb[3], 8'(p4)};
        @(posedge iclk);
        cyc++;
        if (rst) begin
            mCol = 0; mRow = 0; mSync = 1'b0;
            heldX = 0; heldY = 0; heldD = 0;
            for (int i = 0; i < 8; i++) begin
                ringKp[i] = 1'b0;
                ringFd[i] = 1'b0;
            end
        end else begin
            if (stb != 4'h0 && stb != 4'hF) mSync = 1'b1;
            if (stb[0]) accept(p1, p2, p3, p4);
        end
        @(negedge iclk);
        s = cyc % 8;
        checkVal("kp_valid", oKeypoint_valid, ringKp[s]);
        if (ringKp[s]) begin
            heldX = ringX[s];
            heldY = ringY[s];
            heldD = ringD[s];
        end
        checkVal("kp_x", oKeypoint_x, heldX);
        checkVal("kp_y", oKeypoint_y, heldY);
        checkVal("dog", {23'b0, oDoG}, 32'(heldD) & 32'h1FF);
        checkVal("frame_done", oFrame_done, ringFd[s]);
        checkVal("sync_err", oSync_err, mSync);
        ringKp[s] = 1'b0;
        ringFd[s] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 4'h0, $urandom_range(0, 255), $urandom_range(0, 255),
                        $urandom_range(0, 255), $urandom_range(0, 255));
    endtask

    task automatic pixel(input bit [3:0] stb);
        tick(1'b0, stb, img[0][mRow][mCol], img[1][mRow][mCol],
             img[2][mRow][mCol], img[3][mRow][mCol]);
    endtask

    task automatic runFrame(input int gapMax, input int nStrobes);
        for (int k = 0; k < nStrobes; k++) begin
            idle($urandom_range(0, gapMax));
            pixel(4'hF);
        end
    endtask

    task automatic fillImg(input int v);
        for (int g = 0; g < 4; g++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    img[g][y][x] = v;
    endtask

    initial begin
        irst = 1'b1;
        iG1 = '0; iG2 = '0; iG3 = '0; iG4 = '0;
        tick(1'b1, 4'h0, 0, 0, 0, 0);
        tick(1'b1, 4'h0, 0, 0, 0, 0);

        fillImg(100);                 runFrame(0, 48); idle(4);
        fillImg(0); img[2][2][3] = 20; runFrame(0, 48); idle(4);
        runFrame(3, 48);                                idle(4);
        img[2][2][3] = 3;             runFrame(1, 48); idle(4);
        img[2][2][3] = 4;             runFrame(1, 48); idle(4);

        fillImg(0); img[2][2][0] = 20; runFrame(1, 48);
        fillImg(0); img[2][2][7] = 20; runFrame(1, 48);
        fillImg(0); img[2][5][3] = 20; runFrame(1, 48); idle(4);

        fillImg(0); img[2][2][3] = 20; img[2][2][4] = 20; runFrame(1, 48);
        fillImg(0); img[1][2][3] = 20;                    runFrame(1, 48); idle(4);

        fillImg(0); img[2][2][3] = 20;
        runFrame(1, 20);
        tick(1'b1, 4'h0, 0, 0, 0, 0);
        runFrame(1, 48); idle(4);

        for (int f = 0; f < 16; f++) begin
            for (int g = 0; g < 4; g++)
                for (int y = 0; y < H; y++)
                    for (int x = 0; x < W; x++)
                        img[g][y][x] = $urandom_range(0, 3);
            repeat ($urandom_range(1, 4))
                img[$urandom_range(0, 3)][$urandom_range(1, H - 2)][$urandom_range(1, W - 2)]
                    = $urandom_range(4, 255);
            runFrame(3, 48);
        end
        idle(4);

        fillImg(0); img[2][2][3] = 20;
        runFrame(0, 10);
        pixel(4'b1011);
        runFrame(1, 37);
        idle(6);
        tick(1'b1, 4'h0, 0, 0, 0, 0);
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
